octree_walker: RTL and testbench
================================

Name: octree_walker

Overview:
- Upstream neighbour of the ray stepper. Given a query position q, it descends a sparse voxel octree held in external memory and returns three things: the leaf's axis-aligned bounding box (l, u), the leaf's material, and the leaf's depth.
- The stepper consumes l/u to advance the ray to the box exit. The exit point is then fed back here as the next q.
- The block keeps one memory read outstanding at a time and exposes a start/done interface.

Parameters:
- WIDTH, 16, coordinate width per axis; also the maximum octree depth.
- ADDR_WIDTH, 16, octree memory word-address width.
- ROOT_ADDR, 0, memory address of the root node.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  restarts the walk; q is latched every cycle start is high; the walk begins on the first cycle start is low.
- q  input  3 x WIDTH  query position {x,y,z}, unsigned.
- done  output  1  high when idle or finished; low while walking.
- error  output  1  walk reached depth WIDTH at a non-leaf node; valid when done.
- l  output  3 x WIDTH  leaf lower bound per axis.
- u  output  3 x WIDTH  leaf upper bound per axis (inclusive).
- material  output  24  leaf payload.
- depth  output  $clog2(WIDTH+1)  leaf depth; root = 0.
- memReqValid  output  1  read request valid.
- memReqReady  input  1  memory accepts the request.
- memReqAddr  output  ADDR_WIDTH  read address.
- memRespValid  input  1  read data valid; there is no backpressure on responses.
- memRespData  input  32  node word.

Behaviour:
- Reset values: done=1, error=0, l=u=0, material=0, depth=0, memReqValid=0, state IDLE, drop flag clear.
- Node word format:
  - bit31=1: leaf; material = bits[23:0].
  - bit31=0: internal node; child base = bits[ADDR_WIDTH-1:0].
  - Other bits are ignored.
- States: IDLE, LOAD, REQ, WAIT.
- IDLE: done=1. On start go to LOAD.
- LOAD (start high):
  - Latch q.
  - Set addr=ROOT_ADDR, depth=0.
  - Set done=0 and error=0.
  - When start is low, go to REQ.
- REQ: memReqValid=1 with memReqAddr=addr. Address and valid stay stable until the handshake (valid & ready). On handshake go to WAIT.
- WAIT: on memRespValid, the next state depends on the node word:
  - Leaf:
    - material <= data[23:0].
    - For each axis i: l[i] <= q[i] with the low (WIDTH-depth) bits cleared.
    - u[i] <= l[i] with the low (WIDTH-depth) bits set.
    - done <= 1; go to IDLE.
  - Internal node with depth == WIDTH: error <= 1, done <= 1, go to IDLE. l, u and material keep their previous values.
  - Internal node otherwise:
    - octant = {q[2][WIDTH-1-depth], q[1][WIDTH-1-depth], q[0][WIDTH-1-depth]}, i.e. z is the MSB.
    - addr <= base + octant, modulo 2^ADDR_WIDTH.
    - depth <= depth+1; go to REQ.
- Latency:
  - Let T be the first edge at which start is sampled low. memReqValid is 1 after T.
  - With memReqReady tied high and the response arriving one cycle after acceptance, a root leaf gives done=1 after edge T+2.
  - Each extra level adds 2 cycles.
  - Every additional cycle of ready stall or response delay adds 1 cycle.
- Outputs l, u, material, depth and error change only on completion or on reset/start. They hold their values while done=1.
- start during REQ: abort and return to LOAD. A request not yet accepted is simply withdrawn.
- start during WAIT:
  - Abort and set the drop flag.
  - The next memRespValid is discarded and the flag clears.
  - A REQ issued while the flag is set must wait until the flag clears before asserting memReqValid.
  - The response that clears the flag and a new handshake may not occur in the same cycle.
- start is ignored for the cycle reset is high; reset has priority everywhere.
- memRespValid while in IDLE/REQ with the drop flag clear: ignored.
- depth == WIDTH leaf: l = u = q (a unit voxel). A depth-0 leaf gives l=0, u=all ones.

Test Plan:
- Root leaf: mem[0]=0x8000_0042, q=(5,6,7), ready=1, 1-cycle response -> done after T+2, material=0x000042, l=(0,0,0), u=(0xFFFF,0xFFFF,0xFFFF), depth=0.
- Two levels: mem[0]=0x0000_0008, mem[9]=0x80AB_CDEF, q=(0x8000,0,0) -> memReqAddr 0 then 9, material=0xABCDEF, l=(0x8000,0,0), u=(0xFFFF,0x7FFF,0x7FFF), depth=1, done after T+4.
- Backpressure: same image as the two-level case, memReqReady low for 3 cycles per request -> memReqAddr/memReqValid stable during the stall, identical results, done 6 cycles later.
- Depth overflow: every address holds an internal node pointing to base 0 -> after 16 descents the next internal node sets error=1, done=1; l/u/material unchanged from the previous walk.
- Abort in WAIT: start pulsed while the response to addr 0 is pending, new q=(0,0,0xFFFF), response delayed 4 cycles -> stale response dropped, new request to ROOT_ADDR issued only afterwards, final result matches the new q.
- Reset mid-walk: reset asserted in WAIT -> next cycle done=1, memReqValid=0, all outputs zero; a subsequent walk completes normally.

Source files
------------

// File: rtl/octree_walker.sv
// Sparse voxel octree descent: walks from the root toward the leaf containing q,
// one memory read in flight at a time, and reports the leaf box, material and depth.
module octree_walker #(
    parameter int                    WIDTH      = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ROOT_ADDR  = '0
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [2:0][WIDTH-1:0]        q_i,
    output logic                         done_o,
    output logic                         error_o,
    output logic [2:0][WIDTH-1:0]        l_o,
    output logic [2:0][WIDTH-1:0]        u_o,
    output logic [23:0]                  material_o,
    output logic [$clog2(WIDTH+1)-1:0]   depth_o,
    output logic                         memReqValid_o,
    input  logic                         memReqReady_i,
    output logic [ADDR_WIDTH-1:0]        memReqAddr_o,
    input  logic                         memRespValid_i,
    input  logic [31:0]                  memRespData_i
);
    localparam int DW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic [2:0][WIDTH-1:0] qpos_q, qpos_d, l_q, l_d, u_q, u_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         lvl_q, lvl_d, depth_q, depth_d;
    logic [23:0]           mat_q, mat_d;
    logic                  done_q, done_d, err_q, err_d, drop_q, drop_d;

    logic [WIDTH-1:0]        low_mask;
    logic [2:0][WIDTH-1:0]   qsh;
    logic [2:0]              octant;
    logic                    is_leaf, at_bottom, req_fire;
    logic                    unused_bits;

    assign unused_bits = ^memRespData_i[30:24];
    assign is_leaf     = memRespData_i[31];
    assign at_bottom   = (lvl_q == DW'(WIDTH));

    assign memReqValid_o = (state_q == REQ) && !drop_q;
    assign memReqAddr_o  = addr_q;
    assign req_fire      = memReqValid_o && memReqReady_i;

    // Bits below the current level span the node's extent on each axis.
    always_comb begin
        low_mask = {WIDTH{1'b1}} >> lvl_q;
        for (int i = 0; i < 3; i++) begin
            qsh[i]    = qpos_q[i] << lvl_q;
            octant[i] = qsh[i][WIDTH-1];
        end
    end

    always_comb begin
        state_d = state_q;
        qpos_d  = qpos_q;
        addr_d  = addr_q;
        lvl_d   = lvl_q;
        depth_d = depth_q;
        l_d     = l_q;
        u_d     = u_q;
        mat_d   = mat_q;
        done_d  = done_q;
        err_d   = err_q;
        drop_d  = drop_q;
        if (drop_q && memRespValid_i)
            drop_d = 1'b0;
        if (start_i) begin
            state_d = LOAD;
            qpos_d  = q_i;
            addr_d  = ROOT_ADDR;
            lvl_d   = '0;
            depth_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            // An accepted read whose response is still to come must be swallowed.
            if ((state_q == WAIT && !memRespValid_i) || (state_q == REQ && req_fire))
                drop_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: state_d = REQ;
                REQ:  if (req_fire) state_d = WAIT;
                WAIT: if (memRespValid_i) begin
                    if (is_leaf) begin
                        mat_d = memRespData_i[23:0];
                        for (int i = 0; i < 3; i++) begin
                            l_d[i] = qpos_q[i] & ~low_mask;
                            u_d[i] = qpos_q[i] | low_mask;
                        end
                        depth_d = lvl_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (at_bottom) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = memRespData_i[ADDR_WIDTH-1:0] + ADDR_WIDTH'(octant);
                        lvl_d   = lvl_q + DW'(1);
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            qpos_q  <= '0;
            addr_q  <= ROOT_ADDR;
            lvl_q   <= '0;
            depth_q <= '0;
            l_q     <= '0;
            u_q     <= '0;
            mat_q   <= '0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qpos_q  <= qpos_d;
            addr_q  <= addr_d;
            lvl_q   <= lvl_d;
            depth_q <= depth_d;
            l_q     <= l_d;
            u_q     <= u_d;
            mat_q   <= mat_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign done_o     = done_q;
    assign error_o    = err_q;
    assign l_o        = l_q;
    assign u_o        = u_q;
    assign material_o = mat_q;
    assign depth_o    = depth_q;
endmodule

// File: tb/tb_octree_walker.sv
// Directed bench for octree_walker: a memory responder, a descent model over a
// small node image, and a per-cycle comparison of the held results.
module tb_octree_walker;
    localparam int W  = 16;
    localparam int AW = 16;
    localparam int DW = $clog2(W+1);

    logic clk = 1'b0;
    logic rst, start;
    logic [2:0][W-1:0] q;
    logic done, error;
    logic [2:0][W-1:0] l, u;
    logic [23:0] material;
    logic [DW-1:0] depth;
    logic req_v, req_rdy, resp_v;
    logic [AW-1:0] req_addr;
    logic [31:0] resp_data;

    octree_walker #(.WIDTH(W), .ADDR_WIDTH(AW), .ROOT_ADDR('0)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .q_i(q),
        .done_o(done), .error_o(error), .l_o(l), .u_o(u),
        .material_o(material), .depth_o(depth),
        .memReqValid_o(req_v), .memReqReady_i(req_rdy), .memReqAddr_o(req_addr),
        .memRespValid_i(resp_v), .memRespData_i(resp_data)
    );

    always #5 clk = ~clk;

    int n_vec, n_err;
    bit chk_on;
    logic [31:0] mem [0:255];
    logic [AW-1:0] exp_q [$];
    int n_reads;
    logic [2:0][W-1:0] pend_l, pend_u, exp_l, exp_u;
    logic [23:0] pend_mat, exp_mat;
    logic [DW-1:0] pend_dep, exp_dep;
    logic pend_err, exp_err;
    int stall_n, resp_dly, stall_cnt, resp_timer;
    logic [31:0] resp_word;
    bit prev_pend;
    logic [AW-1:0] prev_addr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int a);
        if (a >= 0 && a < 256) return mem[a];
        return 32'h0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    // Descent by plain arithmetic: leaf box is q rounded down to a multiple of 2^(W-d).
    task automatic model_walk(input logic [2:0][W-1:0] qv);
        int a, d, oct;
        logic [31:0] w;
        longint sz, lv;
        exp_q.delete();
        a = 0;
        for (d = 0; d <= W; d++) begin
            exp_q.push_back(AW'(a));
            w = mem_rd(a);
            if (w[31]) begin
                sz = longint'(1) << (W - d);
                for (int i = 0; i < 3; i++) begin
                    lv = longint'(qv[i]);
                    lv = (lv / sz) * sz;
                    pend_l[i] = W'(lv);
                    pend_u[i] = W'(lv + sz - 1);
                end
                pend_mat = w[23:0];
                pend_dep = DW'(d);
                pend_err = 1'b0;
                break;
            end
            if (d == W) begin
                pend_err = 1'b1;
                pend_dep = '0;
                break;
            end
            oct = 0;
            for (int i = 0; i < 3; i++)
                oct += int'((qv[i] >> (W - 1 - d)) & 16'd1) << i;
            a = (int'(w[AW-1:0]) + oct) % (1 << AW);
        end
        n_reads = exp_q.size();
    endtask

    task automatic zero_expect();
        pend_l = '0; pend_u = '0; pend_mat = '0; pend_dep = '0; pend_err = 1'b0;
        exp_l  = '0; exp_u  = '0; exp_mat  = '0; exp_dep  = '0; exp_err  = 1'b0;
    endtask

    // Memory responder: stalls ready, returns mem[addr] resp_dly cycles after acceptance.
    initial begin
        req_rdy = 1'b0; resp_v = 1'b0; resp_data = '0;
        stall_cnt = 0; resp_timer = 0; resp_word = '0; prev_pend = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            resp_v = 1'b0;
            if (resp_timer > 0) begin
                resp_timer--;
                if (resp_timer == 0) begin
                    resp_v = 1'b1;
                    resp_data = resp_word;
                end
            end
            if (prev_pend) begin
                chk("req_hold_valid", 64'(req_v), 64'(1));
                chk("req_hold_addr", 64'(req_addr), 64'(prev_addr));
            end
            prev_pend = 0;
            if (req_v === 1'b1) begin
                chk("one_outstanding", 64'(resp_timer > 0 || resp_v), 64'(0));
                if (stall_cnt < stall_n) begin
                    req_rdy = 1'b0;
                    stall_cnt++;
                    prev_pend = !start && !rst;
                    prev_addr = req_addr;
                end else begin
                    req_rdy = 1'b1;
                    stall_cnt = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 64'(req_addr), 64'hFFFF_FFFF);
                    end else begin
                        chk("req_addr", 64'(req_addr), 64'(exp_q.pop_front()));
                    end
                    resp_word = mem_rd(int'(req_addr));
                    resp_timer = resp_dly;
                end
            end else begin
                req_rdy = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Held results must match the model on every idle cycle.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            if (done !== 1'b1) begin
                exp_l = pend_l; exp_u = pend_u; exp_mat = pend_mat;
                exp_dep = pend_dep; exp_err = pend_err;
            end else begin
                chk("l", 64'(l), 64'(exp_l));
                chk("u", 64'(u), 64'(exp_u));
                chk("material", 64'(material), 64'(exp_mat));
                chk("error", 64'(error), 64'(exp_err));
                if (!exp_err) chk("depth", 64'(depth), 64'(exp_dep));
                chk("idle_req", 64'(req_v), 64'(0));
            end
        end
    end

    task automatic wait_done(input int exp_lat);
        int k;
        bit seen;
        seen = 0;
        for (k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL walk_timeout: done %b after 400 cycles, expected 1", done);
        end else if (exp_lat >= 0) begin
            chk("latency", 64'(k), 64'(exp_lat));
        end
    endtask

    task automatic run_walk(input logic [2:0][W-1:0] qv, input int st, input int dl, input bit lat_chk);
        stall_n = st; resp_dly = dl;
        model_walk(qv);
        @(posedge clk); #1 start = 1'b1; q = qv;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        wait_done(lat_chk ? n_reads * (1 + st + dl) : -1);
    endtask

    task automatic two_level_image();
        clear_mem();
        mem[0]  = 32'h0000_0008;
        mem[9]  = 32'h80AB_CDEF;
        mem[12] = 32'h8012_3456;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_reqv"}, 64'(req_v), 64'(0));
        chk({tag, "_l"}, 64'(l), 64'(0));
        chk({tag, "_u"}, 64'(u), 64'(0));
        chk({tag, "_mat"}, 64'(material), 64'(0));
        chk({tag, "_depth"}, 64'(depth), 64'(0));
        chk({tag, "_err"}, 64'(error), 64'(0));
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_on = 0;
        rst = 1'b1; start = 1'b0; q = '0;
        stall_n = 0; resp_dly = 1;
        zero_expect();
        clear_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");
        chk_on = 1;

        // Root leaf
        mem[0] = 32'h8000_0042;
        run_walk({16'd7, 16'd6, 16'd5}, 0, 1, 1);
        chk("root_mat", 64'(material), 64'h42);
        chk("root_l", 64'(l), 64'h0);
        chk("root_u", 64'(u), 64'hFFFF_FFFF_FFFF);
        chk("root_depth", 64'(depth), 64'd0);

        // Two levels, then the same with ready stalls
        two_level_image();
        run_walk({16'h0, 16'h0, 16'h8000}, 0, 1, 1);
        chk("lvl2_mat", 64'(material), 64'hABCDEF);
        chk("lvl2_l", 64'(l), {16'h0, 16'h0000, 16'h0000, 16'h8000});
        chk("lvl2_u", 64'(u), {16'h0, 16'h7FFF, 16'h7FFF, 16'hFFFF});
        chk("lvl2_depth", 64'(depth), 64'd1);
        run_walk({16'h0, 16'h0, 16'h8000}, 3, 1, 1);
        chk("stall_mat", 64'(material), 64'hABCDEF);
        chk("stall_depth", 64'(depth), 64'd1);

        // Depth overflow: every node internal with base 0
        clear_mem();
        run_walk({16'd3, 16'd2, 16'd1}, 0, 1, 1);
        chk("ovf_err", 64'(error), 64'd1);
        chk("ovf_mat", 64'(material), 64'hABCDEF);
        chk("ovf_l", 64'(l), {16'h0, 16'h0000, 16'h0000, 16'h8000});

        // Unit-voxel leaf at full depth
        clear_mem();
        for (int d = 0; d < 16; d++) mem[8*d] = 32'(8*(d+1));
        mem[129] = 32'h8000_BEEF;
        run_walk({16'd0, 16'd0, 16'd1}, 0, 1, 1);
        chk("deep_l", 64'(l), 64'h1);
        chk("deep_u", 64'(u), 64'h1);
        chk("deep_depth", 64'(depth), 64'd16);
        chk("deep_err", 64'(error), 64'd0);

        // Abort while the root read is outstanding
        two_level_image();
        stall_n = 0; resp_dly = 4;
        model_walk({16'h0, 16'h0, 16'h8000});
        @(posedge clk); #1 start = 1'b1; q = {16'h0, 16'h0, 16'h8000};
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 model_walk({16'hFFFF, 16'h0, 16'h0});
        start = 1'b1; q = {16'hFFFF, 16'h0, 16'h0};
        @(posedge clk); #1 start = 1'b0;
        wait_done(-1);
        chk("abort_mat", 64'(material), 64'h123456);
        chk("abort_l", 64'(l), {16'h0, 16'h8000, 16'h0000, 16'h0000});
        chk("abort_u", 64'(u), {16'h0, 16'hFFFF, 16'h7FFF, 16'h7FFF});
        chk("abort_depth", 64'(depth), 64'd1);

        // Reset while waiting on a response, then a clean walk
        stall_n = 0; resp_dly = 4;
        model_walk({16'h0, 16'h0, 16'h8000});
        @(posedge clk); #1 start = 1'b1; q = {16'h0, 16'h0, 16'h8000};
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        zero_expect();
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_state("midrst");
        repeat (8) @(posedge clk);
        run_walk({16'h0, 16'h0, 16'h8000}, 0, 1, 1);
        chk("postrst_mat", 64'(material), 64'hABCDEF);
        chk("postrst_depth", 64'(depth), 64'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
